// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver driven by an OSR-times oversample tick.
// Deserialises rxd into a holding register with ready/ack handshake and
// sticky overrun / framing-error flags. All outputs are registered.
module uart_rx #(
   parameter int unsigned OSR = 8
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       tick,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   input  logic       rx_ack,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned  TW    = (OSR > 2) ? $clog2(OSR) : 1;
   localparam logic [TW-1:0] T_MID = TW'(OSR / 2 - 1);
   localparam logic [TW-1:0] T_END = TW'(OSR - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT
   } state_t;

   state_t        state_q,     state_d;
   logic          sync1_q,     sync1_d;
   logic          rxs_q,       rxs_d;
   logic [TW-1:0] tcnt_q,      tcnt_d;
   logic [2:0]    bcnt_q,      bcnt_d;
   logic [7:0]    sr_q,        sr_d;
   logic [7:0]    rx_data_q,   rx_data_d;
   logic          rx_ready_q,  rx_ready_d;
   logic          overrun_q,   overrun_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q,      busy_d;

   // Next-state: synchroniser, bit timing FSM, handshake and commit
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      bcnt_d      = bcnt_q;
      sr_d        = sr_q;
      rx_data_d   = rx_data_q;
      rx_ready_d  = rx_ready_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      sync1_d     = rxd;
      rxs_d       = sync1_q;

      // Ack is applied before any commit in the same cycle, so a
      // simultaneous ack + commit leaves rx_ready set without overrun.
      if (rx_ack) begin
         frame_err_d = 1'b0;
         if (rx_ready_q) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
         end
      end

      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rxs_q) begin
                  tcnt_d  = '0;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (tcnt_q == T_MID) begin
                  if (rxs_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     tcnt_d  = '0;
                     bcnt_d  = '0;
                     state_d = ST_DATA;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (tcnt_q == T_END) begin
                  tcnt_d = '0;
                  sr_d   = {rxs_q, sr_q[7:1]};
                  if (bcnt_q == 3'd7) begin
                     state_d = ST_STOP;
                  end else begin
                     bcnt_d = bcnt_q + 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (tcnt_q == T_END) begin
                  tcnt_d = '0;
                  if (rxs_q) begin
                     rx_data_d  = sr_q;
                     rx_ready_d = 1'b1;
                     if (rx_ready_q && !rx_ack) begin
                        overrun_d = 1'b1;
                     end
                     state_d = ST_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_WAIT;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (rxs_q) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // All state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         tcnt_q      <= '0;
         bcnt_q      <= '0;
         sr_q        <= '0;
         rx_data_q   <= '0;
         rx_ready_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rxs_q       <= rxs_d;
         tcnt_q      <= tcnt_d;
         bcnt_q      <= bcnt_d;
         sr_q        <= sr_d;
         rx_data_q   <= rx_data_d;
         rx_ready_q  <= rx_ready_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_ready  = rx_ready_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a byte-level model of
// the receiver's handshake and flags.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned OSR      = 8;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned BIT_CLK  = OSR * TICK_DIV;
   // start edge to stop-bit sample, in clk cycles, measured from busy rising
   localparam int unsigned COMMIT_CLK = (OSR / 2 + 9 * OSR) * TICK_DIV;

   logic       clk;
   logic       n_reset;
   logic       tick;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_ack;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   int n_cmp = 0;
   int n_mis = 0;
   int tph   = 0;

   // reference model state (byte-level, not bit-level)
   logic [7:0] m_data;
   logic       m_ready;
   logic       m_over;
   logic       m_ferr;

   uart_rx #(.OSR(OSR)) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .tick      (tick),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .rx_ack    (rx_ack),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // 100 MHz-style clock, tick every TICK_DIV cycles
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clk);
         tph  = (tph + 1) % TICK_DIV;
         tick = (tph == 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".data"},  32'(rx_data),   32'(m_data));
      check_val({tag, ".ready"}, 32'(rx_ready),  32'(m_ready));
      check_val({tag, ".over"},  32'(overrun),   32'(m_over));
      check_val({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
   endtask

   task automatic model_reset();
      m_data  = 8'h00;
      m_ready = 1'b0;
      m_over  = 1'b0;
      m_ferr  = 1'b0;
   endtask

   task automatic model_ack();
      m_ferr = 1'b0;
      if (m_ready) begin
         m_ready = 1'b0;
         m_over  = 1'b0;
      end
   endtask

   task automatic model_commit(input logic [7:0] b);
      if (m_ready) m_over = 1'b1;
      m_data  = b;
      m_ready = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic do_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      model_ack();
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   // returns on the posedge (+1) where busy is first seen high
   task automatic wait_busy_rise(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("busy_rise_timeout", 32'(busy), 32'd1);
   endtask

   initial begin
      bit         ok;
      logic [7:0] b;
      logic       bad;
      int         gap;

      n_reset = 1'b0;
      rxd     = 1'b1;
      rx_ack  = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      check_all("rst");
      check_val("rst.busy", 32'(busy), 32'd0);
      n_reset = 1'b1;

      // idle line with ticks running: nothing moves for 100 bit periods
      for (int i = 0; i < 100; i++) begin
         repeat (BIT_CLK) @(negedge clk);
         check_val("idle", {19'd0, busy, rx_ready, overrun, frame_err, rx_data}, 32'd0);
      end

      // 0x55 with exact commit timing relative to the detected start
      fork
         send_frame(8'h55, 1'b1);
         begin
            wait_busy_rise(ok);
            if (ok) begin
               repeat (COMMIT_CLK - 1) @(posedge clk);
               #1 check_val("t55.pre_ready", 32'(rx_ready), 32'd0);
               @(posedge clk);
               #1 check_val("t55.post_ready", 32'(rx_ready), 32'd1);
               check_val("t55.post_data", 32'(rx_data), 32'h55);
            end
         end
      join
      model_commit(8'h55);
      check_all("t55");
      do_ack();
      check_all("t55.ack");

      // back-to-back frames without ack -> overrun
      send_frame(8'hA3, 1'b1);
      model_commit(8'hA3);
      send_frame(8'h0F, 1'b1);
      model_commit(8'h0F);
      check_all("b2b");
      do_ack();
      check_all("b2b.ack");

      // two-tick glitch aborts in START
      rxd = 1'b0;
      repeat (2 * TICK_DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * BIT_CLK) @(negedge clk);
      check_all("glitch");
      check_val("glitch.busy", 32'(busy), 32'd0);
      send_frame(8'hC6, 1'b1);
      model_commit(8'hC6);
      check_all("c6");
      do_ack();

      // bad stop bit followed by a held-low line
      send_frame(8'h81, 1'b0);
      m_ferr = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      check_all("ferr");
      check_val("ferr.busy_wait", 32'(busy), 32'd1);
      rxd = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      check_val("ferr.busy_idle", 32'(busy), 32'd0);
      send_frame(8'h3C, 1'b1);
      model_commit(8'h3C);
      check_all("3c");

      // reset during data bit 4 of 0xFF, with ready and frame_err set
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
            #3 n_reset = 1'b0;
            model_reset();
            #1 check_all("midrst");
            check_val("midrst.busy", 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            n_reset = 1'b1;
         end
      join
      check_all("postrst");
      check_val("postrst.busy", 32'(busy), 32'd0);
      send_frame(8'h12, 1'b1);
      model_commit(8'h12);
      check_all("12");
      do_ack();

      // ack in the same cycle as the commit of 0x77 while holding 0x11
      send_frame(8'h11, 1'b1);
      model_commit(8'h11);
      check_all("11");
      fork
         send_frame(8'h77, 1'b1);
         begin
            wait_busy_rise(ok);
            if (ok) begin
               repeat (COMMIT_CLK - 1) @(posedge clk);
               @(negedge clk);
               rx_ack = 1'b1;
               @(negedge clk);
               rx_ack = 1'b0;
            end
         end
      join
      model_ack();
      model_commit(8'h77);
      check_all("ack_commit");

      // randomized frames, gaps, bad stops and acks
      for (int n = 0; n < 24; n++) begin
         gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
         rxd = 1'b1;
         repeat (gap) @(negedge clk);
         b   = 8'($urandom);
         bad = ($urandom_range(0, 6) == 0);
         send_frame(b, !bad);
         if (bad) begin
            m_ferr = 1'b1;
            rxd    = 1'b1;
            repeat (3 * TICK_DIV) @(negedge clk);
         end else begin
            model_commit(b);
         end
         check_all($sformatf("rnd%0d", n));
         if ($urandom_range(0, 1) == 1) begin
            do_ack();
            check_all($sformatf("rnd%0d.ack", n));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
